mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all address ports.
REQ-002 Parameter DATA_W, default 32: data width of all data ports.
REQ-003 Parameter TIMEOUT, default 16: maximum busy cycles per transaction before abort; legal range 2..255.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_req  in  1  instruction-fetch request, level; held until i_ready.
REQ-007 i_addr  in  ADDR_W  fetch address; stable while i_req is high.
REQ-008 d_read  in  1  data-load request, level; held until d_ready.
REQ-009 d_write  in  1  data-store request, level; held until d_ready.
REQ-010 d_addr  in  ADDR_W  data address; stable while a data request is high.
REQ-011 d_wdata  in  DATA_W  store data; stable while d_write is high.
REQ-012 i_ready  out  1  one-cycle pulse: fetch finished.
REQ-013 i_rdata  out  DATA_W  fetched instruction; valid when i_ready=1, held until the next fetch completes.
REQ-014 d_ready  out  1  one-cycle pulse: data access finished.
REQ-015 d_rdata  out  DATA_W  load data; valid when d_ready=1, held until the next data access completes.
REQ-016 err  out  1  one-cycle pulse coincident with i_ready or d_ready when the access timed out.
REQ-017 mem_read  out  1  memory read strobe.
REQ-018 mem_write  out  1  memory write strobe.
REQ-019 mem_addr  out  ADDR_W  registered memory address.
REQ-020 mem_wdata  out  DATA_W  registered memory write data.
REQ-021 mem_rdata  in  DATA_W  memory read data; sampled on the completion cycle.
REQ-022 mem_busy  in  1  memory stall; an access completes in a strobe cycle with mem_busy=0.

Function
REQ-023 FSM states: IDLE, FETCH, DATA, DONE.
REQ-024 IDLE: a data request (d_read|d_write) goes to DATA, else i_req goes to FETCH, else stay; data has fixed priority over fetch.
REQ-025 On the grant edge: latch address, write data and op into mem_addr/mem_wdata/op register.
REQ-026 FETCH/DATA: mem_read (fetch or load) or mem_write (store) is high every cycle until completion.
REQ-027 Completion (strobe high, mem_busy=0): capture mem_rdata into i_rdata (FETCH) or d_rdata (DATA load); go to DONE.
REQ-028 A store does not modify d_rdata.
REQ-029 DONE lasts exactly one cycle: strobes low, matching ready=1, then IDLE unconditionally; requests are ignored in DONE.
REQ-030 Minimum latency: request seen in IDLE at cycle 0, strobe at cycle 1, ready at cycle 2, next grant possible at cycle 3.
REQ-031 d_read and d_write both high: treated as a store, and the read is not performed.
REQ-032 A requester dropping its request mid-access does not abort the access; ready still pulses.
REQ-033 Wait counter clears on grant and increments each busy strobe cycle.
REQ-034 Abort when the counter reaches TIMEOUT: rdata = 0, err=1 together with ready in DONE.
REQ-035 i_ready and d_ready are never high in the same cycle.

Reset
REQ-036 rst=1 at an edge: state IDLE; mem_read, mem_write, i_ready, d_ready and err = 0; mem_addr, mem_wdata, i_rdata, d_rdata and counter = 0.
REQ-037 Reset during FETCH/DATA/DONE discards the access with no ready pulse; the strobes are low from the next cycle.

Structure
REQ-038 Shared package mem_arb_pkg holds: the state enum typedef, the op enum (OP_FETCH, OP_LOAD, OP_STORE), and the TIMEOUT default constant.
REQ-039 The wait counter is a sub-module wait_timer (clear, enable, limit, expired).

Verification
REQ-040 i_req=1, i_addr=0x0000_0004, mem_busy=0, mem_rdata=0x3E80_0093 -> mem_read at cycle 1, then i_ready=1 and i_rdata=0x3E80_0093 at cycle 2.
REQ-041 i_req and d_read both high in IDLE, d_addr=0x100 -> DATA is granted first with mem_addr=0x100; the fetch follows after DONE.
REQ-042 d_write=1, d_addr=0x200, d_wdata=0xDEAD_BEEF, mem_busy=1 for 3 cycles -> mem_write high for 4 cycles, then d_ready; d_rdata unchanged.
REQ-043 mem_busy held 1 with TIMEOUT=16 -> strobe for 16 cycles, then d_ready=1, err=1, d_rdata=0.
REQ-044 rst asserted in the second cycle of FETCH -> strobes 0 and state IDLE at the next edge; no i_ready pulse.
REQ-045 d_read and d_write both high -> mem_write only, mem_read stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 16;
   localparam int unsigned CNT_W           = 8;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StData,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      OP_FETCH,
      OP_LOAD,
      OP_STORE
   } op_e;

endpackage

// File: rtl/wait_timer.sv
// Busy-cycle counter for one memory access; flags the busy cycle that reaches the limit.
module wait_timer
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + 1'b1;
      end
   end

   // Raised on the busy cycle whose increment would bring the count to the limit.
   assign expired = enable && (count_q == limit - 1'b1);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto a single memory port; data wins over fetch.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_busy
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] irdata_q, irdata_d;
   logic [DATA_W-1:0] drdata_q, drdata_d;
   logic              err_q, err_d;

   logic strobe;
   logic expired;
   logic complete;
   logic abort;

   assign strobe   = (state_q == StFetch) || (state_q == StData);
   assign complete = strobe && !mem_busy;
   assign abort    = expired;

   wait_timer u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q == StIdle),
      .enable  (strobe && mem_busy),
      .limit   (CNT_W'(TIMEOUT)),
      .expired (expired)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      err_d    = err_q;
      unique case (state_q)
         StIdle: begin
            err_d = 1'b0;
            if (d_read || d_write) begin
               state_d = StData;
               op_d    = d_write ? OP_STORE : OP_LOAD;
               addr_d  = d_addr;
               wdata_d = d_wdata;
            end else if (i_req) begin
               state_d = StFetch;
               op_d    = OP_FETCH;
               addr_d  = i_addr;
            end
         end
         StFetch, StData: begin
            if (complete || abort) begin
               state_d = StDone;
               err_d   = abort;
               if (op_q == OP_FETCH) begin
                  irdata_d = abort ? '0 : mem_rdata;
               end else if (op_q == OP_LOAD) begin
                  drdata_d = abort ? '0 : mem_rdata;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         op_q     <= OP_FETCH;
         addr_q   <= '0;
         wdata_q  <= '0;
         irdata_q <= '0;
         drdata_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         err_q    <= err_d;
      end
   end

   assign mem_read  = (state_q == StFetch) || (state_q == StData && op_q == OP_LOAD);
   assign mem_write = (state_q == StData) && (op_q == OP_STORE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_rdata   = irdata_q;
   assign d_rdata   = drdata_q;

   // A reset arriving while DONE is showing suppresses the pulse so the access is discarded.
   assign i_ready = (state_q == StDone) && (op_q == OP_FETCH) && !rst;
   assign d_ready = (state_q == StDone) && (op_q != OP_FETCH) && !rst;
   assign err     = (state_q == StDone) && err_q && !rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_busy;

   mem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .d_read    (d_read),
      .d_write   (d_write),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .i_ready   (i_ready),
      .i_rdata   (i_rdata),
      .d_ready   (d_ready),
      .d_rdata   (d_rdata),
      .err       (err),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_busy  (mem_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one in-flight transaction described by kind, elapsed busy cycles, done flag.
   localparam int KFetch = 0;
   localparam int KLoad  = 1;
   localparam int KStore = 2;

   bit          m_active, m_done, m_err;
   int          m_kind, m_waited;
   logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
   int          strobe_cnt;
   bit          last_iready, last_dready;

   task automatic model_reset();
      m_active = 0; m_done = 0; m_err = 0; m_kind = KFetch; m_waited = 0;
      m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
   endtask

   task automatic model_clock();
      if (rst) begin
         model_reset();
      end else if (m_done) begin
         m_done = 0;
         m_err  = 0;
      end else if (m_active) begin
         if (!mem_busy || m_waited + 1 == TO) begin
            m_err    = mem_busy;
            m_active = 0;
            m_done   = 1;
            if (m_kind == KFetch) m_irdata = mem_busy ? 32'h0 : mem_rdata;
            if (m_kind == KLoad)  m_drdata = mem_busy ? 32'h0 : mem_rdata;
         end else begin
            m_waited++;
         end
      end else if (d_read || d_write) begin
         m_active = 1; m_waited = 0;
         m_kind   = d_write ? KStore : KLoad;
         m_addr   = d_addr;
         m_wdata  = d_wdata;
      end else if (i_req) begin
         m_active = 1; m_waited = 0;
         m_kind   = KFetch;
         m_addr   = i_addr;
      end
   endtask

   // One clock: compare outputs mid-cycle, then advance the model at the edge.
   task automatic step();
      bit er, ew, eir, edr;
      @(negedge clk);
      er  = m_active && m_kind != KStore;
      ew  = m_active && m_kind == KStore;
      eir = m_done && m_kind == KFetch && !rst;
      edr = m_done && m_kind != KFetch && !rst;
      check_eq("mem_read", mem_read, er);
      check_eq("mem_write", mem_write, ew);
      check_eq("i_ready", i_ready, eir);
      check_eq("d_ready", d_ready, edr);
      check_eq("err", err, m_done && m_err && !rst);
      check_eq("mem_addr", mem_addr, m_addr);
      check_eq("i_rdata", i_rdata, m_irdata);
      check_eq("d_rdata", d_rdata, m_drdata);
      if (ew) check_eq("mem_wdata", mem_wdata, m_wdata);
      check_eq("ready_excl", i_ready & d_ready, 0);
      if (er || ew) strobe_cnt++;
      last_iready = eir;
      last_dready = edr;
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic drive_random(input int busy_pct);
      int k;
      if (last_iready) i_req = 0;
      if (last_dready) begin d_read = 0; d_write = 0; end
      if (!i_req && $urandom_range(2) == 0) begin
         i_req  = 1;
         i_addr = $urandom & 32'hFFFF_FFFC;
      end else if (i_req && $urandom_range(39) == 0) begin
         i_req = 0;
      end
      if (!d_read && !d_write && $urandom_range(2) == 0) begin
         k       = int'($urandom_range(3));
         d_read  = (k != 2);
         d_write = (k >= 2);
         d_addr  = $urandom;
         d_wdata = $urandom;
      end else if ((d_read || d_write) && $urandom_range(39) == 0) begin
         d_read = 0; d_write = 0;
      end
      mem_busy  = int'($urandom_range(99)) < busy_pct;
      mem_rdata = $urandom;
      rst       = ($urandom_range(299) == 0);
   endtask

   initial begin
      logic [31:0] saved;
      int          s0;
      rst = 1; i_req = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; mem_busy = 0;
      model_reset();
      strobe_cnt = 0; last_iready = 0; last_dready = 0;
      @(posedge clk); #1;
      step(); step();
      rst = 0;
      step();

      // Single fetch with no stall.
      i_req = 1; i_addr = 32'h4; mem_rdata = 32'h3E80_0093;
      step();
      check_eq("t040_read_c1", mem_read, 1);
      step();
      check_eq("t040_ready_c2", i_ready, 1);
      check_eq("t040_rdata_c2", i_rdata, 32'h3E80_0093);
      i_req = 0;
      step(); step();

      // Data beats fetch when both are pending.
      i_req = 1; i_addr = 32'h40; d_read = 1; d_addr = 32'h100; mem_rdata = 32'h1234_5678;
      step();
      check_eq("t041_data_first", mem_addr, 32'h100);
      step(); d_read = 0;
      step(); step();
      check_eq("t041_fetch_next", mem_addr, 32'h40);
      step(); i_req = 0;
      step(); step();

      // Store stalled for three cycles.
      saved = 32'h1234_5678;
      d_write = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; mem_busy = 1;
      step();
      s0 = strobe_cnt;
      step(); step(); step();
      mem_busy = 0;
      step();
      check_eq("t042_ready", d_ready, 1);
      check_eq("t042_strobes", strobe_cnt - s0, 4);
      check_eq("t042_rdata_kept", d_rdata, saved);
      d_write = 0;
      step(); step();

      // Load that never completes hits the timeout.
      d_read = 1; d_addr = 32'h300; mem_busy = 1;
      step();
      s0 = strobe_cnt;
      for (int i = 0; i < TO; i++) step();
      check_eq("t043_strobes", strobe_cnt - s0, TO);
      check_eq("t043_ready", d_ready, 1);
      check_eq("t043_err", err, 1);
      check_eq("t043_rdata", d_rdata, 0);
      d_read = 0; mem_busy = 0;
      step(); step();

      // Reset in the second FETCH cycle drops the access.
      i_req = 1; i_addr = 32'h80; mem_busy = 1;
      step(); step();
      rst = 1;
      step();
      rst = 0; i_req = 0; mem_busy = 0;
      check_eq("t044_read_off", mem_read, 0);
      step();
      check_eq("t044_no_ready", i_ready, 0);
      step();

      // Read and write together act as a store.
      d_read = 1; d_write = 1; d_addr = 32'h400; d_wdata = 32'hCAFE_F00D;
      step();
      check_eq("t045_write", mem_write, 1);
      check_eq("t045_no_read", mem_read, 0);
      step(); d_read = 0; d_write = 0;
      step(); step();

      for (int i = 0; i < 3000; i++) begin
         drive_random(30);
         step();
      end
      for (int i = 0; i < 1500; i++) begin
         drive_random(90);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
